pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush and hold; data_o/valid_o are driven from flops.
// Define PIPE_STAGE_REG_SKID_EN for a main+skid pair that keeps ready_o free of any ready_i path.
`default_nettype none

module pipe_stage_reg #(
  parameter int                 DATA_W     = 64,
  parameter logic [DATA_W-1:0]  FLUSH_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  logic              main_vld_q, main_vld_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              ready_base;
  logic              accept;
  logic              pop;

  // Any control event that disturbs the stage also closes the upstream side.
  assign ready_o = ready_base & ~hold_i & ~flush_i & ~rst_i;
  assign accept  = valid_i & ready_o;
  assign pop     = main_vld_q & ready_i & ~hold_i & ~rst_i;

  assign valid_o = main_vld_q;
  assign data_o  = main_data_q;

`ifdef PIPE_STAGE_REG_SKID_EN

  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  assign ready_base = ~skid_vld_q;
  assign occ_o      = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (!hold_i) begin
      if (flush_i) begin
        main_vld_d  = 1'b0;
        main_data_d = FLUSH_DATA;
        skid_vld_d  = 1'b0;
      end else if (skid_vld_q) begin
        // Skid holds the older beat; it drains into main before anything new is taken.
        if (pop) begin
          main_vld_d  = 1'b1;
          main_data_d = skid_data_q;
          skid_vld_d  = 1'b0;
        end
      end else if (!main_vld_q || pop) begin
        main_vld_d  = accept;
        main_data_d = accept ? data_i : FLUSH_DATA;
      end else if (accept) begin
        skid_vld_d  = 1'b1;
        skid_data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_vld_q <= 1'b0;
    end else begin
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    skid_data_q <= skid_data_d;
  end

`else

  assign ready_base = ~main_vld_q | ready_i;
  assign occ_o      = {1'b0, main_vld_q};

  always_comb begin
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    if (!hold_i) begin
      if (flush_i) begin
        main_vld_d  = 1'b0;
        main_data_d = FLUSH_DATA;
      end else if (!main_vld_q || pop) begin
        main_vld_d  = accept;
        main_data_d = accept ? data_i : FLUSH_DATA;
      end
    end
  end

`endif

  // Output register: data_o is reset too, so an empty stage always shows FLUSH_DATA.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_vld_q  <= 1'b0;
      main_data_q <= FLUSH_DATA;
    end else begin
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
    end
  end

endmodule

`default_nettype wire
